// File: rtl/store_commit_buffer.sv
// Write-combining store buffer: retired stores merge per line, drain to the
// DCache in FIFO order, and can be forwarded to loads through a probe port.
module store_commit_buffer #(
    parameter int ENTRY_NUM       = 4,
    parameter int LINE_BYTES      = 16,
    parameter int ADDR_WIDTH      = 32,
    parameter int DRAIN_THRESHOLD = 3,
    parameter int AGE_LIMIT       = 64
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         enqValid,
    output logic                                         enqReady,
    input  logic [ADDR_WIDTH-$clog2(LINE_BYTES)-1:0]     enqLineAddr,
    input  logic [LINE_BYTES*8-1:0]                      enqData,
    input  logic [LINE_BYTES-1:0]                        enqByteWE,
    input  logic                                         drainAll,
    output logic                                         empty,
    output logic [$clog2(ENTRY_NUM):0]                   count,
    output logic                                         dcWriteReq,
    output logic [ADDR_WIDTH-1:0]                        dcWriteAddr,
    output logic [LINE_BYTES*8-1:0]                      dcWriteData,
    output logic [LINE_BYTES-1:0]                        dcWriteByteWE,
    input  logic                                         dcWriteReqAck,
    input  logic [ADDR_WIDTH-$clog2(LINE_BYTES)-1:0]     ldProbeLineAddr,
    output logic                                         ldHit,
    output logic [LINE_BYTES-1:0]                        ldByteValid,
    output logic [LINE_BYTES*8-1:0]                      ldData
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int LINE_W = ADDR_WIDTH - OFF_W;
    localparam int DATA_W = LINE_BYTES * 8;
    localparam int PTR_W  = $clog2(ENTRY_NUM);
    localparam int CNT_W  = PTR_W + 1;
    localparam int AGE_W  = $clog2(AGE_LIMIT + 1);

    typedef enum logic { ST_IDLE, ST_REQ } state_t;

    state_t                state_q, state_d;
    logic [ENTRY_NUM-1:0]  valid_q, valid_d;
    logic [ENTRY_NUM-1:0]  locked_q, locked_d;
    logic [LINE_W-1:0]     line_q [ENTRY_NUM];
    logic [LINE_W-1:0]     line_d [ENTRY_NUM];
    logic [DATA_W-1:0]     data_q [ENTRY_NUM];
    logic [DATA_W-1:0]     data_d [ENTRY_NUM];
    logic [LINE_BYTES-1:0] we_q [ENTRY_NUM];
    logic [LINE_BYTES-1:0] we_d [ENTRY_NUM];
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [AGE_W-1:0]      age_q, age_d;
    logic                  drain_pending_q, drain_pending_d;

    logic                  merge_hit, do_merge, do_alloc, do_ack;
    logic [PTR_W-1:0]      merge_idx;
    logic [DATA_W-1:0]     enq_mask;
    logic                  pending_any, lock_en;
    logic [PTR_W-1:0]      lock_idx;
    logic [PTR_W-1:0]      probe_idx;

    // Locate the unlocked entry for the incoming line and decide merge vs allocate.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (valid_q[i] && !locked_q[i] && line_q[i] == enqLineAddr) begin
                merge_hit = 1'b1;
                merge_idx = PTR_W'(i);
            end
        end
        enq_mask = '0;
        for (int b = 0; b < LINE_BYTES; b++) begin
            enq_mask[b*8 +: 8] = {8{enqByteWE[b]}};
        end
        enqReady = merge_hit || (count_q < CNT_W'(ENTRY_NUM));
        do_merge = enqValid && (|enqByteWE) && merge_hit;
        do_alloc = enqValid && (|enqByteWE) && !merge_hit && (count_q < CNT_W'(ENTRY_NUM));
        do_ack   = (state_q == ST_REQ) && dcWriteReqAck;
    end

    // Drain policy, pointer/occupancy bookkeeping, age counter and fence latch.
    always_comb begin
        count_d     = count_q + CNT_W'(do_alloc) - CNT_W'(do_ack);
        head_d      = head_q + PTR_W'(do_ack);
        tail_d      = tail_q + PTR_W'(do_alloc);
        pending_any = drain_pending_q || drainAll;
        state_d     = state_q;
        lock_en     = 1'b0;
        lock_idx    = head_q;
        case (state_q)
            ST_IDLE: begin
                if ((count_q >= CNT_W'(DRAIN_THRESHOLD)) ||
                    (pending_any && count_q != '0) ||
                    (age_q == AGE_W'(AGE_LIMIT))) begin
                    state_d  = ST_REQ;
                    lock_en  = 1'b1;
                    lock_idx = head_q;
                end
            end
            ST_REQ: begin
                if (do_ack) begin
                    if (((count_d >= CNT_W'(DRAIN_THRESHOLD)) || pending_any) && count_d != '0) begin
                        lock_en  = 1'b1;
                        lock_idx = head_d;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        age_d = '0;
        if (state_q == ST_IDLE && state_d == ST_IDLE && count_q != '0) begin
            age_d = (age_q == AGE_W'(AGE_LIMIT)) ? age_q : age_q + AGE_W'(1);
        end
        drain_pending_d = pending_any && (count_d != '0);
    end

    // Entry array updates: free the acked head, merge, allocate, then lock the next head.
    always_comb begin
        valid_d  = valid_q;
        locked_d = locked_q;
        line_d   = line_q;
        data_d   = data_q;
        we_d     = we_q;
        if (do_ack) begin
            valid_d[head_q]  = 1'b0;
            locked_d[head_q] = 1'b0;
        end
        if (do_merge) begin
            data_d[merge_idx] = (data_q[merge_idx] & ~enq_mask) | (enqData & enq_mask);
            we_d[merge_idx]   = we_q[merge_idx] | enqByteWE;
        end
        if (do_alloc) begin
            valid_d[tail_q]  = 1'b1;
            locked_d[tail_q] = 1'b0;
            line_d[tail_q]   = enqLineAddr;
            data_d[tail_q]   = enqData & enq_mask;
            we_d[tail_q]     = enqByteWE;
        end
        if (lock_en) begin
            locked_d[lock_idx] = 1'b1;
        end
    end

    // Load forwarding: walk oldest to youngest so younger bytes overwrite older ones.
    always_comb begin
        ldByteValid = '0;
        ldData      = '0;
        probe_idx   = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            probe_idx = head_q + PTR_W'(i);
            if (valid_q[probe_idx] && line_q[probe_idx] == ldProbeLineAddr) begin
                for (int b = 0; b < LINE_BYTES; b++) begin
                    if (we_q[probe_idx][b]) begin
                        ldByteValid[b]  = 1'b1;
                        ldData[b*8 +: 8] = data_q[probe_idx][b*8 +: 8];
                    end
                end
            end
        end
        ldHit = |ldByteValid;
    end

    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign dcWriteReq    = (state_q == ST_REQ);
    assign dcWriteAddr   = dcWriteReq ? {line_q[head_q], {OFF_W{1'b0}}} : '0;
    assign dcWriteData   = dcWriteReq ? data_q[head_q] : '0;
    assign dcWriteByteWE = dcWriteReq ? we_q[head_q] : '0;

    // All state registers; reset abandons any in-flight DCache write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            valid_q         <= '0;
            locked_q        <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            age_q           <= '0;
            drain_pending_q <= 1'b0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                line_q[i] <= '0;
                data_q[i] <= '0;
                we_q[i]   <= '0;
            end
        end else begin
            state_q         <= state_d;
            valid_q         <= valid_d;
            locked_q        <= locked_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            age_q           <= age_d;
            drain_pending_q <= drain_pending_d;
            line_q          <= line_d;
            data_q          <= data_d;
            we_q            <= we_d;
        end
    end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer with a queue-based reference model.
module tb_store_commit_buffer;

    localparam int ENTRY_NUM       = 4;
    localparam int LINE_BYTES      = 16;
    localparam int ADDR_WIDTH      = 32;
    localparam int DRAIN_THRESHOLD = 3;
    localparam int AGE_LIMIT       = 64;
    localparam int LW              = ADDR_WIDTH - 4;
    localparam int DW              = LINE_BYTES * 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  enqValid = 1'b0;
    logic                  enqReady;
    logic [LW-1:0]         enqLineAddr = '0;
    logic [DW-1:0]         enqData = '0;
    logic [LINE_BYTES-1:0] enqByteWE = '0;
    logic                  drainAll = 1'b0;
    logic                  empty;
    logic [2:0]            count;
    logic                  dcWriteReq;
    logic [ADDR_WIDTH-1:0] dcWriteAddr;
    logic [DW-1:0]         dcWriteData;
    logic [LINE_BYTES-1:0] dcWriteByteWE;
    logic                  dcWriteReqAck = 1'b0;
    logic [LW-1:0]         ldProbeLineAddr = '0;
    logic                  ldHit;
    logic [LINE_BYTES-1:0] ldByteValid;
    logic [DW-1:0]         ldData;

    int checks = 0;
    int failures = 0;

    store_commit_buffer #(
        .ENTRY_NUM(ENTRY_NUM), .LINE_BYTES(LINE_BYTES), .ADDR_WIDTH(ADDR_WIDTH),
        .DRAIN_THRESHOLD(DRAIN_THRESHOLD), .AGE_LIMIT(AGE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .enqValid(enqValid), .enqReady(enqReady), .enqLineAddr(enqLineAddr),
        .enqData(enqData), .enqByteWE(enqByteWE), .drainAll(drainAll),
        .empty(empty), .count(count),
        .dcWriteReq(dcWriteReq), .dcWriteAddr(dcWriteAddr), .dcWriteData(dcWriteData),
        .dcWriteByteWE(dcWriteByteWE), .dcWriteReqAck(dcWriteReqAck),
        .ldProbeLineAddr(ldProbeLineAddr), .ldHit(ldHit),
        .ldByteValid(ldByteValid), .ldData(ldData)
    );

    always #5 clk = ~clk;

    // Reference model: oldest entry at index 0; locked marks the head being written.
    typedef struct packed {
        logic [LW-1:0]         line;
        logic [DW-1:0]         data;
        logic [LINE_BYTES-1:0] we;
        logic                  locked;
    } ment_t;

    ment_t mq[$];

    function automatic logic [DW-1:0] expand(input logic [LINE_BYTES-1:0] we);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < LINE_BYTES; b++) m[b*8 +: 8] = {8{we[b]}};
        return m;
    endfunction

    function automatic bit model_ready(input logic [LW-1:0] line);
        foreach (mq[i]) if (!mq[i].locked && mq[i].line == line) return 1'b1;
        return mq.size() < ENTRY_NUM;
    endfunction

    function automatic void model_enq(input logic [LW-1:0] line, input logic [DW-1:0] data,
                                      input logic [LINE_BYTES-1:0] we);
        ment_t e;
        if (we == '0) return;
        foreach (mq[i]) begin
            if (!mq[i].locked && mq[i].line == line) begin
                e = mq[i];
                e.data = (e.data & ~expand(we)) | (data & expand(we));
                e.we = e.we | we;
                mq[i] = e;
                return;
            end
        end
        e.line = line;
        e.data = data & expand(we);
        e.we = we;
        e.locked = 1'b0;
        mq.push_back(e);
    endfunction

    function automatic void model_probe(input logic [LW-1:0] line, output logic [LINE_BYTES-1:0] v,
                                        output logic [DW-1:0] d);
        v = '0;
        d = '0;
        foreach (mq[i]) begin
            if (mq[i].line == line) begin
                for (int b = 0; b < LINE_BYTES; b++) begin
                    if (mq[i].we[b]) begin
                        v[b] = 1'b1;
                        d[b*8 +: 8] = mq[i].data[b*8 +: 8];
                    end
                end
            end
        end
    endfunction

    function automatic void model_lock_head();
        ment_t e;
        e = mq[0];
        e.locked = 1'b1;
        mq[0] = e;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        enqValid = 1'b0;
        enqByteWE = '0;
        drainAll = 1'b0;
        dcWriteReqAck = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        mq.delete();
        step();
    endtask

    // Presents one store for a cycle; model is updated only if the model accepts it.
    task automatic enq(input logic [LW-1:0] line, input logic [DW-1:0] data,
                       input logic [LINE_BYTES-1:0] we, output logic rdy_obs, output logic rdy_exp);
        rdy_exp = model_ready(line);
        enqValid = 1'b1;
        enqLineAddr = line;
        enqData = data;
        enqByteWE = we;
        #2;
        rdy_obs = enqReady;
        @(posedge clk);
        if (rdy_exp) model_enq(line, data, we);
        #1;
        enqValid = 1'b0;
        enqByteWE = '0;
    endtask

    task automatic test_reset();
        do_reset();
        ldProbeLineAddr = '0;
        #1;
        checks += 10;
        if (empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        if (count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        if (enqReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_enqReady: got %b expected 1", enqReady); end
        if (dcWriteReq !== 1'b0) begin failures++; $display("[TB] FAIL reset_dcWriteReq: got %b expected 0", dcWriteReq); end
        if (dcWriteAddr !== '0) begin failures++; $display("[TB] FAIL reset_dcWriteAddr: got %h expected 0", dcWriteAddr); end
        if (dcWriteData !== '0) begin failures++; $display("[TB] FAIL reset_dcWriteData: got %h expected 0", dcWriteData); end
        if (dcWriteByteWE !== '0) begin failures++; $display("[TB] FAIL reset_dcWriteByteWE: got %h expected 0", dcWriteByteWE); end
        if (ldHit !== 1'b0) begin failures++; $display("[TB] FAIL reset_ldHit: got %b expected 0", ldHit); end
        if (ldByteValid !== '0) begin failures++; $display("[TB] FAIL reset_ldByteValid: got %h expected 0", ldByteValid); end
        if (ldData !== '0) begin failures++; $display("[TB] FAIL reset_ldData: got %h expected 0", ldData); end
    endtask

    task automatic test_merge();
        logic ro, re;
        do_reset();
        enq(LW'('h10), DW'(128'h44332211), 16'h000F, ro, re);
        enq(LW'('h10), DW'(128'h6655), 16'h0003, ro, re);
        ldProbeLineAddr = LW'('h10);
        #1;
        checks += 4;
        if (count !== 3'd1) begin failures++; $display("[TB] FAIL merge_count: got %0d expected 1", count); end
        if (ldHit !== 1'b1) begin failures++; $display("[TB] FAIL merge_ldHit: got %b expected 1", ldHit); end
        if (ldByteValid !== 16'h000F) begin failures++; $display("[TB] FAIL merge_valid: got %h expected 000f", ldByteValid); end
        if (ldData !== DW'(128'h44336655)) begin failures++; $display("[TB] FAIL merge_data: got %h expected 44336655", ldData); end
    endtask

    task automatic test_random_probe();
        logic ro, re;
        logic [LW-1:0] lines [3];
        logic [LINE_BYTES-1:0] ev, we;
        logic [DW-1:0] ed;
        int sel;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            lines[0] = LW'($urandom_range(1, 1000));
            lines[1] = lines[0] + LW'($urandom_range(1, 50));
            lines[2] = lines[0] + LW'(2000);
            for (int s = 0; s < 8; s++) begin
                sel = $urandom_range(0, 1);
                we = LINE_BYTES'($urandom());
                if ($urandom_range(0, 5) == 0) we = '0;
                enq(lines[sel], rand_data(), we, ro, re);
                checks += 2;
                if (ro !== re) begin failures++; $display("[TB] FAIL rand_enqReady: got %b expected %b", ro, re); end
                if (count !== 3'(mq.size())) begin failures++; $display("[TB] FAIL rand_count: got %0d expected %0d", count, mq.size()); end
                for (int k = 0; k < 3; k++) begin
                    ldProbeLineAddr = lines[k];
                    #1;
                    model_probe(lines[k], ev, ed);
                    checks += 3;
                    if (ldHit !== (ev != '0)) begin failures++; $display("[TB] FAIL rand_ldHit: got %b expected %b", ldHit, (ev != '0)); end
                    if (ldByteValid !== ev) begin failures++; $display("[TB] FAIL rand_ldByteValid: got %h expected %h", ldByteValid, ev); end
                    if (ldData !== ed) begin failures++; $display("[TB] FAIL rand_ldData: got %h expected %h", ldData, ed); end
                end
            end
        end
    endtask

    // Threshold drain start, store to locked head line, full-buffer backpressure, then back-to-back acks.
    task automatic test_threshold_back_to_back();
        logic ro, re;
        logic [LW-1:0] la, lb, lc, ld;
        logic [LINE_BYTES-1:0] ev;
        logic [DW-1:0] ed;
        do_reset();
        la = LW'('h100); lb = LW'('h200); lc = LW'('h300); ld = LW'('h400);
        enq(la, rand_data(), 16'h00FF, ro, re);
        enq(lb, rand_data(), 16'hF000, ro, re);
        enq(lc, rand_data(), 16'h0FF0, ro, re);
        checks += 2;
        if (count !== 3'd3) begin failures++; $display("[TB] FAIL thr_count3: got %0d expected 3", count); end
        if (dcWriteReq !== 1'b0) begin failures++; $display("[TB] FAIL thr_req_early: got %b expected 0", dcWriteReq); end
        step();
        model_lock_head();
        checks += 2;
        if (dcWriteReq !== 1'b1) begin failures++; $display("[TB] FAIL thr_req: got %b expected 1", dcWriteReq); end
        if (dcWriteAddr !== {la, 4'h0}) begin failures++; $display("[TB] FAIL thr_addr: got %h expected %h", dcWriteAddr, {la, 4'h0}); end
        enq(la, rand_data(), 16'h0F0F, ro, re);
        checks += 4;
        if (ro !== re) begin failures++; $display("[TB] FAIL head_line_ready: got %b expected %b", ro, re); end
        if (count !== 3'd4) begin failures++; $display("[TB] FAIL head_line_count: got %0d expected 4", count); end
        if (dcWriteByteWE !== mq[0].we) begin failures++; $display("[TB] FAIL head_stable_we: got %h expected %h", dcWriteByteWE, mq[0].we); end
        if ((dcWriteData & expand(mq[0].we)) !== mq[0].data) begin failures++; $display("[TB] FAIL head_stable_data: got %h expected %h", dcWriteData & expand(mq[0].we), mq[0].data); end
        ldProbeLineAddr = la;
        #1;
        model_probe(la, ev, ed);
        checks += 2;
        if (ldByteValid !== ev) begin failures++; $display("[TB] FAIL two_hit_valid: got %h expected %h", ldByteValid, ev); end
        if (ldData !== ed) begin failures++; $display("[TB] FAIL two_hit_data: got %h expected %h", ldData, ed); end
        enq(ld, rand_data(), 16'h0001, ro, re);
        checks += 2;
        if (ro !== 1'b0 || re !== 1'b0) begin failures++; $display("[TB] FAIL full_enqReady: got %b expected 0", ro); end
        if (count !== 3'd4) begin failures++; $display("[TB] FAIL full_count: got %0d expected 4", count); end
        enq(lb, rand_data(), 16'h000F, ro, re);
        checks += 2;
        if (ro !== re) begin failures++; $display("[TB] FAIL full_merge_ready: got %b expected %b", ro, re); end
        if (count !== 3'd4) begin failures++; $display("[TB] FAIL full_merge_count: got %0d expected 4", count); end

        dcWriteReqAck = 1'b1;
        @(posedge clk);
        void'(mq.pop_front());
        #1;
        model_lock_head();
        checks += 4;
        if (dcWriteReq !== 1'b1) begin failures++; $display("[TB] FAIL b2b_req2: got %b expected 1", dcWriteReq); end
        if (dcWriteAddr !== {lb, 4'h0}) begin failures++; $display("[TB] FAIL b2b_addr2: got %h expected %h", dcWriteAddr, {lb, 4'h0}); end
        if ((dcWriteData & expand(mq[0].we)) !== mq[0].data) begin failures++; $display("[TB] FAIL b2b_data2: got %h expected %h", dcWriteData & expand(mq[0].we), mq[0].data); end
        if (count !== 3'd3) begin failures++; $display("[TB] FAIL b2b_count3: got %0d expected 3", count); end
        @(posedge clk);
        void'(mq.pop_front());
        #1;
        dcWriteReqAck = 1'b0;
        checks += 2;
        if (count !== 3'd2) begin failures++; $display("[TB] FAIL b2b_count2: got %0d expected 2", count); end
        if (dcWriteReq !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle: got %b expected 0", dcWriteReq); end
        step();
        ldProbeLineAddr = lb;
        #1;
        checks += 2;
        if (dcWriteReq !== 1'b0) begin failures++; $display("[TB] FAIL b2b_stay_idle: got %b expected 0", dcWriteReq); end
        if (ldHit !== 1'b0) begin failures++; $display("[TB] FAIL b2b_freed_probe: got %b expected 0", ldHit); end
        ldProbeLineAddr = la;
        #1;
        model_probe(la, ev, ed);
        checks += 2;
        if (ldByteValid !== ev) begin failures++; $display("[TB] FAIL b2b_young_valid: got %h expected %h", ldByteValid, ev); end
        if (ldData !== ed) begin failures++; $display("[TB] FAIL b2b_young_data: got %h expected %h", ldData, ed); end
    endtask

    task automatic test_age();
        logic ro, re;
        int early;
        do_reset();
        enq(LW'('h55), rand_data(), 16'h8001, ro, re);
        early = 0;
        for (int c = 1; c <= AGE_LIMIT; c++) begin
            if (dcWriteReq !== 1'b0) early++;
            step();
        end
        step();
        checks += 3;
        if (early != 0) begin failures++; $display("[TB] FAIL age_early_req: got %0d high cycles expected 0", early); end
        if (dcWriteReq !== 1'b1) begin failures++; $display("[TB] FAIL age_req: got %b expected 1", dcWriteReq); end
        if (dcWriteAddr !== {LW'('h55), 4'h0}) begin failures++; $display("[TB] FAIL age_addr: got %h expected %h", dcWriteAddr, {LW'('h55), 4'h0}); end
        dcWriteReqAck = 1'b1;
        step();
        dcWriteReqAck = 1'b0;
        checks += 2;
        if (empty !== 1'b1) begin failures++; $display("[TB] FAIL age_empty: got %b expected 1", empty); end
        if (dcWriteReq !== 1'b0) begin failures++; $display("[TB] FAIL age_req_drop: got %b expected 0", dcWriteReq); end
    endtask

    // Fence below threshold drains everything; afterwards the fence must not linger.
    task automatic test_drain_all();
        logic ro, re;
        int late;
        do_reset();
        enq(LW'('h70), rand_data(), 16'h00F0, ro, re);
        enq(LW'('h71), rand_data(), 16'h0F00, ro, re);
        drainAll = 1'b1;
        step();
        drainAll = 1'b0;
        checks += 2;
        if (dcWriteReq !== 1'b1) begin failures++; $display("[TB] FAIL drain_req1: got %b expected 1", dcWriteReq); end
        if (dcWriteAddr !== {LW'('h70), 4'h0}) begin failures++; $display("[TB] FAIL drain_addr1: got %h expected %h", dcWriteAddr, {LW'('h70), 4'h0}); end
        dcWriteReqAck = 1'b1;
        step();
        checks += 2;
        if (dcWriteReq !== 1'b1) begin failures++; $display("[TB] FAIL drain_req2: got %b expected 1", dcWriteReq); end
        if (dcWriteAddr !== {LW'('h71), 4'h0}) begin failures++; $display("[TB] FAIL drain_addr2: got %h expected %h", dcWriteAddr, {LW'('h71), 4'h0}); end
        step();
        dcWriteReqAck = 1'b0;
        checks += 2;
        if (empty !== 1'b1) begin failures++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
        if (dcWriteReq !== 1'b0) begin failures++; $display("[TB] FAIL drain_idle: got %b expected 0", dcWriteReq); end
        enq(LW'('h72), rand_data(), 16'h0001, ro, re);
        late = 0;
        for (int c = 0; c < 6; c++) begin
            if (dcWriteReq !== 1'b0) late++;
            step();
        end
        checks++;
        if (late != 0) begin failures++; $display("[TB] FAIL drain_pending_clear: got %0d req cycles expected 0", late); end
    endtask

    task automatic test_reset_mid_req();
        logic ro, re;
        do_reset();
        enq(LW'('h90), rand_data(), 16'hFFFF, ro, re);
        enq(LW'('h91), rand_data(), 16'h0001, ro, re);
        drainAll = 1'b1;
        step();
        drainAll = 1'b0;
        ldProbeLineAddr = LW'('h90);
        #2;
        rst = 1'b0;
        #1;
        checks += 7;
        if (dcWriteReq !== 1'b0) begin failures++; $display("[TB] FAIL rmid_req: got %b expected 0", dcWriteReq); end
        if (dcWriteAddr !== '0) begin failures++; $display("[TB] FAIL rmid_addr: got %h expected 0", dcWriteAddr); end
        if (dcWriteData !== '0) begin failures++; $display("[TB] FAIL rmid_data: got %h expected 0", dcWriteData); end
        if (count !== 3'd0) begin failures++; $display("[TB] FAIL rmid_count: got %0d expected 0", count); end
        if (empty !== 1'b1) begin failures++; $display("[TB] FAIL rmid_empty: got %b expected 1", empty); end
        if (enqReady !== 1'b1) begin failures++; $display("[TB] FAIL rmid_enqReady: got %b expected 1", enqReady); end
        if (ldHit !== 1'b0) begin failures++; $display("[TB] FAIL rmid_ldHit: got %b expected 0", ldHit); end
        #3;
        rst = 1'b1;
        mq.delete();
        step();
        for (int k = 0; k < 2; k++) begin
            ldProbeLineAddr = LW'('h90 + k);
            #1;
            checks += 2;
            if (ldHit !== 1'b0) begin failures++; $display("[TB] FAIL rpost_ldHit: got %b expected 0", ldHit); end
            if (ldByteValid !== '0) begin failures++; $display("[TB] FAIL rpost_valid: got %h expected 0", ldByteValid); end
        end
    endtask

    initial begin
        test_reset();
        test_merge();
        test_random_probe();
        test_threshold_back_to_back();
        test_age();
        test_drain_all();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guards against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
